npc_state_unit: RTL and testbench

- Architectural state and selection block of the single-cycle NPC core: 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file, program-counter register, and a keyed lookup multiplexer with default.
- Sits between the decoder (register addresses, opcode keys) and the execute adder and next-PC logic.
- All state updates happen on the rising edge of a single clock.

---
 rtl/npc_state_unit.sv | 96 +++++++++
 tb/tb_npc_state_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_state_unit.sv
// Architectural state of the NPC core: GPR file, PC register and keyed lookup mux.
// Optional write-through read forwarding is enabled by defining NPC_REGFILE_BYPASS_EN.
module npc_state_unit #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h8000_0000,
    parameter int                    NR_KEY     = 4,
    parameter int                    KEY_LEN    = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wen,
    input  logic [ADDR_WIDTH-1:0]                 waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic [ADDR_WIDTH-1:0]                 rs1addr,
    input  logic [ADDR_WIDTH-1:0]                 rs2addr,
    output logic [DATA_WIDTH-1:0]                 rs1data,
    output logic [DATA_WIDTH-1:0]                 rs2data,
    input  logic                                  pc_wen,
    input  logic [DATA_WIDTH-1:0]                 pc_din,
    output logic [DATA_WIDTH-1:0]                 pc,
    input  logic [KEY_LEN-1:0]                    key,
    input  logic [DATA_WIDTH-1:0]                 default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_WIDTH)-1:0] lut,
    output logic [DATA_WIDTH-1:0]                 mux_out
);

    localparam int NREGS  = 1 << ADDR_WIDTH;
    localparam int PAIR_W = KEY_LEN + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    always_comb begin
        regs_d = regs_q;
        if (wen && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_wen) begin
            pc_d = pc_din;
        end
    end

    // Reset takes priority over both write enables.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            pc_q   <= PC_RESET;
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
        end
    end

    assign pc = pc_q;

    always_comb begin
        rs1data = (rs1addr == '0) ? '0 : regs_q[rs1addr];
        rs2data = (rs2addr == '0) ? '0 : regs_q[rs2addr];
`ifdef NPC_REGFILE_BYPASS_EN
        // Forward the in-flight write; x0 stays zero and reset blocks forwarding.
        if (rst && wen && (waddr != '0) && (rs1addr == waddr)) begin
            rs1data = wdata;
        end
        if (rst && wen && (waddr != '0) && (rs2addr == waddr)) begin
            rs2data = wdata;
        end
`endif
    end

    logic                  match_any;
    logic [DATA_WIDTH-1:0] match_data;
    logic [PAIR_W-1:0]     pair;

    // Matching pairs OR together; default applies only when nothing matches.
    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        pair       = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            pair = lut[i*PAIR_W +: PAIR_W];
            if (pair[PAIR_W-1 -: KEY_LEN] == key) begin
                match_any  = 1'b1;
                match_data = match_data | pair[DATA_WIDTH-1:0];
            end
        end
        mux_out = match_any ? match_data : default_out;
    end

endmodule

// File: tb/tb_npc_state_unit.sv
// Self-checking bench for npc_state_unit: directed scenarios plus a randomized run
// against a behavioural model of registers, PC and lookup table.
module tb_npc_state_unit;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NK = 4;
    localparam int KL = 7;
    localparam int PW = KL + DW;
    localparam logic [DW-1:0] PC_RST = 32'h8000_0000;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [AW-1:0]     rs1addr;
    logic [AW-1:0]     rs2addr;
    logic [DW-1:0]     rs1data;
    logic [DW-1:0]     rs2data;
    logic              pc_wen;
    logic [DW-1:0]     pc_din;
    logic [DW-1:0]     pc;
    logic [KL-1:0]     key;
    logic [DW-1:0]     default_out;
    logic [NK*PW-1:0]  lut;
    logic [DW-1:0]     mux_out;

    npc_state_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_RESET(PC_RST), .NR_KEY(NK), .KEY_LEN(KL)
    ) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1data(rs1data), .rs2data(rs2data),
        .pc_wen(pc_wen), .pc_din(pc_din), .pc(pc),
        .key(key), .default_out(default_out), .lut(lut), .mux_out(mux_out)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] ref_regs [32];
    logic [DW-1:0] ref_pc;
    logic [KL-1:0] mk [NK];
    logic [DW-1:0] md [NK];

    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef NPC_REGFILE_BYPASS_EN
        if (rst && wen && waddr == a) return wdata;
`endif
        return ref_regs[a];
    endfunction

    function automatic logic [DW-1:0] exp_mux();
        logic [DW-1:0] acc;
        bit hit;
        acc = '0;
        hit = 0;
        foreach (mk[i]) begin
            if (mk[i] == key) begin
                hit = 1;
                acc = acc | md[i];
            end
        end
        return hit ? acc : default_out;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            foreach (ref_regs[i]) ref_regs[i] = '0;
            ref_pc = PC_RST;
        end else begin
            if (wen && waddr != 0) ref_regs[waddr] = wdata;
            if (pc_wen) ref_pc = pc_din;
        end
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic pack_lut();
        for (int i = 0; i < NK; i++) lut[i*PW +: PW] = {mk[i], md[i]};
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rs1addr = AW'(a); rs2addr = AW'(31 - a);
            #1;
            n_checks += 2;
            if (rs1data !== '0) begin
                n_fail++; $display("FAIL %s rs1 x%0d: got %h expected 0", tag, a, rs1data);
            end
            if (rs2data !== '0) begin
                n_fail++; $display("FAIL %s rs2 x%0d: got %h expected 0", tag, 31 - a, rs2data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wen = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
        pc_wen = 1'b1; pc_din = 32'h1234_5678;
        tick();
        rst = 1'b1; wen = 1'b0; pc_wen = 1'b0;
        #1;
        n_checks++;
        if (pc !== PC_RST) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, PC_RST);
        end
        check_all_zero("reset_regs");
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEAD_BEEF);
        rs1addr = 5'd5; rs2addr = 5'd5; #1;
        n_checks += 2;
        if (rs1data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_x5_rs1: got %h expected deadbeef", rs1data);
        end
        if (rs2data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_x5_rs2: got %h expected deadbeef", rs2data);
        end
        write_reg(5'd0, 32'h1234);
        rs1addr = 5'd0; rs2addr = 5'd0; #1;
        n_checks += 2;
        if (rs1data !== '0 || rs2data !== '0) begin
            n_fail += 2; $display("FAIL wr_x0: got %h/%h expected 0", rs1data, rs2data);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] pre_exp;
        write_reg(5'd7, 32'd1);
        wen = 1'b1; waddr = 5'd7; wdata = 32'd2; rs1addr = 5'd7; rs2addr = 5'd0;
`ifdef NPC_REGFILE_BYPASS_EN
        pre_exp = 32'd2;
`else
        pre_exp = 32'd1;
`endif
        #1;
        n_checks += 2;
        if (rs1data !== pre_exp) begin
            n_fail++; $display("FAIL same_cycle_pre: got %h expected %h", rs1data, pre_exp);
        end
        if (rs2data !== '0) begin
            n_fail++; $display("FAIL same_cycle_x0: got %h expected 0", rs2data);
        end
        tick();
        wen = 1'b0; #1;
        n_checks++;
        if (rs1data !== 32'd2) begin
            n_fail++; $display("FAIL same_cycle_post: got %h expected 2", rs1data);
        end
    endtask

    task automatic test_pc();
        pc_wen = 1'b1; pc_din = 32'h8000_0004;
        tick();
        pc_wen = 1'b0;
        n_checks++;
        if (pc !== 32'h8000_0004) begin
            n_fail++; $display("FAIL pc_load: got %h expected 80000004", pc);
        end
        for (int i = 0; i < 3; i++) begin
            pc_din = $urandom;
            tick();
            n_checks++;
            if (pc !== 32'h8000_0004) begin
                n_fail++; $display("FAIL pc_hold%0d: got %h expected 80000004", i, pc);
            end
        end
    endtask

    task automatic test_mux();
        lut = {7'h13, 32'hAAAA_0001, 7'h17, 32'hBBBB_0002, 7'h6F, 32'hCCCC_0003, 7'h67, 32'hDDDD_0004};
        mk[3] = 7'h13; md[3] = 32'hAAAA_0001;
        mk[2] = 7'h17; md[2] = 32'hBBBB_0002;
        mk[1] = 7'h6F; md[1] = 32'hCCCC_0003;
        mk[0] = 7'h67; md[0] = 32'hDDDD_0004;
        default_out = 32'h0;
        key = 7'h6F; #1;
        n_checks++;
        if (mux_out !== 32'hCCCC_0003) begin
            n_fail++; $display("FAIL mux_6f: got %h expected cccc0003", mux_out);
        end
        key = 7'h03; #1;
        n_checks++;
        if (mux_out !== 32'h0) begin
            n_fail++; $display("FAIL mux_default0: got %h expected 0", mux_out);
        end
        default_out = 32'h5A5A_1234; #1;
        n_checks++;
        if (mux_out !== 32'h5A5A_1234) begin
            n_fail++; $display("FAIL mux_default: got %h expected 5a5a1234", mux_out);
        end
        foreach (mk[i]) begin
            key = mk[i]; #1;
            n_checks++;
            if (mux_out !== md[i]) begin
                n_fail++; $display("FAIL mux_pair%0d: got %h expected %h", i, mux_out, md[i]);
            end
        end
    endtask

    task automatic test_dup_keys();
        mk[0] = 7'h13; md[0] = 32'h0000_000F;
        mk[1] = 7'h13; md[1] = 32'h0000_00F0;
        mk[2] = 7'h33; md[2] = 32'h1111_0000;
        mk[3] = 7'h37; md[3] = 32'h2222_0000;
        pack_lut();
        key = 7'h13; default_out = 32'hFFFF_FFFF; #1;
        n_checks++;
        if (mux_out !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL mux_dup: got %h expected 000000ff", mux_out);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2, em, ob;
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 0) begin
                foreach (mk[i]) begin
                    mk[i] = KL'($urandom_range(7'h10, 7'h13));
                    md[i] = $urandom;
                end
                pack_lut();
            end
            wen     = 1'($urandom_range(0, 1));
            waddr   = AW'($urandom_range(0, 31));
            wdata   = $urandom;
            rs1addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            rs2addr = AW'($urandom_range(0, 31));
            pc_wen  = ($urandom_range(0, 3) == 0);
            pc_din  = $urandom;
            key     = KL'($urandom_range(7'h0F, 7'h14));
            default_out = $urandom;
            #1;
            exp_q.push_back(exp_read(rs1addr));
            exp_q.push_back(exp_read(rs2addr));
            exp_q.push_back(exp_mux());
            e1 = exp_q.pop_front(); e2 = exp_q.pop_front(); em = exp_q.pop_front();
            n_checks += 3;
            if (rs1data !== e1) begin
                n_fail++; $display("FAIL rand_rs1 n=%0d x%0d: got %h expected %h", n, rs1addr, rs1data, e1);
            end
            if (rs2data !== e2) begin
                n_fail++; $display("FAIL rand_rs2 n=%0d x%0d: got %h expected %h", n, rs2addr, rs2data, e2);
            end
            if (mux_out !== em) begin
                n_fail++; $display("FAIL rand_mux n=%0d key=%h: got %h expected %h", n, key, mux_out, em);
            end
            tick();
            ob = pc;
            n_checks++;
            if (ob !== ref_pc) begin
                n_fail++; $display("FAIL rand_pc n=%0d: got %h expected %h", n, ob, ref_pc);
            end
        end
        wen = 1'b0; pc_wen = 1'b0;
    endtask

    task automatic test_reset_again();
        write_reg(5'd9, 32'hCAFE_F00D);
        rst = 1'b0; wen = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_0BAD;
        rs1addr = 5'd9; rs2addr = 5'd9; pc_wen = 1'b1; pc_din = 32'h0000_0040;
        #1;
        n_checks++;
        if (rs1data !== exp_read(5'd9)) begin
            n_fail++; $display("FAIL rst_no_fwd: got %h expected %h", rs1data, exp_read(5'd9));
        end
        tick();
        rst = 1'b1; wen = 1'b0; pc_wen = 1'b0; #1;
        n_checks++;
        if (pc !== PC_RST) begin
            n_fail++; $display("FAIL reset2_pc: got %h expected %h", pc, PC_RST);
        end
        check_all_zero("reset2_regs");
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        rs1addr = '0; rs2addr = '0; pc_wen = 1'b0; pc_din = '0;
        key = '0; default_out = '0; lut = '0;
        foreach (ref_regs[i]) ref_regs[i] = '0;
        foreach (mk[i]) begin mk[i] = '0; md[i] = '0; end
        ref_pc = PC_RST;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_pc();
        test_mux();
        test_dup_keys();
        test_random();
        test_reset_again();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
